// File: rtl/sipo_br_pkg.sv
// Shared types and constants for the sipo_br_rx serial receiver.
// The optional parity window is enabled by defining SIPO_BR_PARITY_EN.
package sipo_br_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int BR_DIV_DEF = 2;

  // Bits needed for a counter holding 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/br_tick_gen.sv
// Bit-period divider: tick marks the last clock of each BR_DIV-clock window.
// The count restarts from the first cycle of a window whenever en drops.
module br_tick_gen
  import sipo_br_pkg::*;
#(
  parameter int BR_DIV = BR_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(BR_DIV);
  localparam logic [CW-1:0] LAST = CW'(BR_DIV - 1);

  // r_cnt holds (div_cnt - 1), so the first enabled cycle is window position 1
  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // window position counter, wrapping at the end of each bit window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (!en) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == LAST) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_br_rx.sv
// MSB-first serial-to-parallel receiver with a BR_DIV-clock bit window.
// Define SIPO_BR_PARITY_EN to add a trailing even-parity bit window.
module sipo_br_rx
  import sipo_br_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BR_DIV = BR_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              busy,
  output logic              parity_err
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

`ifdef SIPO_BR_PARITY_EN
  function automatic logic par_of(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;
  logic              r_perr;
  logic              w_tick;
  logic              w_done;
  logic              w_perr;
  logic              w_busy;

  assign w_busy = (r_state != IDLE);

  br_tick_gen #(
    .BR_DIV (BR_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_busy),
    .tick (w_tick)
  );

  // next-state, bit counter and shift register update
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_done        = 1'b0;
    w_perr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = SHIFT;
          w_bit_cnt_nxt = BIT_TOP;
          w_shift_nxt   = {DATA_W{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          w_shift_nxt = {r_shift[DATA_W-2:0], sin};
          if (r_bit_cnt == {BW{1'b0}}) begin
`ifdef SIPO_BR_PARITY_EN
            w_state_nxt = PAR;
`else
            w_state_nxt = IDLE;
            w_done      = 1'b1;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - BW'(1);
          end
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      PAR: begin
`ifdef SIPO_BR_PARITY_EN
        // data bits plus the even-parity bit must XOR to zero
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
          w_perr      = par_of(r_shift) ^ sin;
        end else begin
          w_state_nxt = PAR;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= {BW{1'b0}};
      r_shift   <= {DATA_W{1'b0}};
      r_dout    <= {DATA_W{1'b0}};
      r_dvalid  <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_dvalid  <= w_done;
      if (w_done) begin
        r_dout <= w_shift_nxt;
        r_perr <= w_perr;
      end else begin
        r_dout <= r_dout;
        r_perr <= r_perr;
      end
    end
  end

  assign dout       = r_dout;
  assign dvalid     = r_dvalid;
  assign busy       = w_busy;
  assign parity_err = r_perr;

endmodule

// File: tb/tb_sipo_br_rx.sv
// Self-checking bench for sipo_br_rx; reference model is a frame-level timeline
// (start cycle, word, parity bit) from which every expected output is derived.
module tb_sipo_br_rx;

`ifdef SIPO_BR_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DW  = 8;
  localparam int DIV = 2;
  localparam int L   = (DW + PB) * DIV;
  localparam int DW2 = 4;
  localparam int DIV2 = 3;
  localparam int L2  = (DW2 + PB) * DIV2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           sin = 1'b0;
  logic [DW-1:0]  dout;
  logic           dvalid, busy, parity_err;
  logic           s_start = 1'b0;
  logic           s_sin = 1'b0;
  logic [DW2-1:0] s_dout;
  logic           s_dvalid, s_busy, s_perr;

  always #5 clk = ~clk;

  sipo_br_rx #(.DATA_W(DW), .BR_DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin),
    .dout(dout), .dvalid(dvalid), .busy(busy), .parity_err(parity_err)
  );

  sipo_br_rx #(.DATA_W(DW2), .BR_DIV(DIV2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .sin(s_sin),
    .dout(s_dout), .dvalid(s_dvalid), .busy(s_busy), .parity_err(s_perr)
  );

  int n_checks = 0;
  int n_fail = 0;
  int g_t = 0;
  int m_s = -1;          // cycle in which the current frame's start was accepted
  logic [DW-1:0] m_word = '0;
  logic          m_par = 1'b0;
  logic [DW-1:0] e_dout = '0;
  logic          e_busy, e_dvalid;
  logic          e_perr = 1'b0;

  // Derive expected outputs for this cycle and drive the serial line for the active frame.
  task automatic predict(input logic st, input logic rs);
    int k;
    e_busy   = (m_s >= 0) && (g_t >= m_s + 1) && (g_t <= m_s + L);
    e_dvalid = (m_s >= 0) && (g_t == m_s + L + 1);
    if (e_dvalid) begin
      e_dout = m_word;
      e_perr = (PB == 1) ? ((^m_word) ^ m_par) : 1'b0;
    end
    if (e_busy) begin
      k = (g_t - m_s - 1) / DIV;
      sin = (k < DW) ? m_word[DW-1-k] : m_par;
    end else begin
      sin = 1'($urandom);
    end
    start = st;
    rst = rs;
  endtask

  // Apply the cycle's reset/start to the model, then advance one clock.
  task automatic commit(input logic st, input logic rs, input logic [DW-1:0] w, input logic p);
    if (rs) begin
      m_s = -1;
      e_dout = '0;
      e_perr = 1'b0;
    end else if (st && !e_busy) begin
      m_s = g_t;
      m_word = w;
      m_par = p;
    end
    @(posedge clk);
    #1;
    g_t++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL reset dout: got %h want 00", dout); end
    if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset dvalid: got %b want 0", dvalid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset parity_err: got %b want 0", parity_err); end
    if (s_dout !== 4'h0) begin n_fail++; $display("FAIL reset small dout: got %h want 0", s_dout); end
  endtask

  task automatic test_single(input logic [DW-1:0] w, input logic p);
    logic st;
    for (int c = 0; c < L + 4; c++) begin
      st = (c == 0);
      predict(st, 1'b0);
      n_checks += 3;
      if (busy !== e_busy) begin n_fail++; $display("FAIL single busy c%0d: got %b want %b", c, busy, e_busy); end
      if (dvalid !== e_dvalid) begin n_fail++; $display("FAIL single dvalid c%0d: got %b want %b", c, dvalid, e_dvalid); end
      if (dout !== e_dout) begin n_fail++; $display("FAIL single dout c%0d: got %h want %h", c, dout, e_dout); end
      if (e_dvalid) begin
        n_checks++;
        if (parity_err !== e_perr) begin n_fail++; $display("FAIL single parity_err c%0d: got %b want %b", c, parity_err, e_perr); end
      end
      commit(st, 1'b0, w, p);
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    logic [DW-1:0] w;
    int t1, t2;
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 2 * L + 5; c++) begin
      st = (c == 0) || (c == L + 1);
      w = (c == 0) ? 8'h3C : 8'hC3;
      predict(st, 1'b0);
      if (dvalid === 1'b1) begin
        if (t1 < 0) t1 = c; else t2 = c;
      end
      n_checks += 3;
      if (busy !== e_busy) begin n_fail++; $display("FAIL b2b busy c%0d: got %b want %b", c, busy, e_busy); end
      if (dvalid !== e_dvalid) begin n_fail++; $display("FAIL b2b dvalid c%0d: got %b want %b", c, dvalid, e_dvalid); end
      if (dout !== e_dout) begin n_fail++; $display("FAIL b2b dout c%0d: got %h want %h", c, dout, e_dout); end
      commit(st, 1'b0, w, ^w);
    end
    n_checks++;
    if (t2 - t1 != L + 1) begin n_fail++; $display("FAIL b2b spacing: got %0d want %0d", t2 - t1, L + 1); end
  endtask

  task automatic test_start_busy();
    logic st;
    for (int c = 0; c < L + 4; c++) begin
      st = (c == 0) || (c == 5) || (c == 9);
      predict(st, 1'b0);
      n_checks += 3;
      if (busy !== e_busy) begin n_fail++; $display("FAIL busy_start busy c%0d: got %b want %b", c, busy, e_busy); end
      if (dvalid !== e_dvalid) begin n_fail++; $display("FAIL busy_start dvalid c%0d: got %b want %b", c, dvalid, e_dvalid); end
      if (dout !== e_dout) begin n_fail++; $display("FAIL busy_start dout c%0d: got %h want %h", c, dout, e_dout); end
      commit(st, 1'b0, 8'hFF, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic st, rs;
    logic [DW-1:0] w;
    for (int c = 0; c < L + 16; c++) begin
      st = (c == 0) || (c == 12);
      rs = (c == 8);
      w = (c == 0) ? 8'h81 : 8'h42;
      predict(st, rs);
      n_checks += 3;
      if (busy !== e_busy) begin n_fail++; $display("FAIL rst_mid busy c%0d: got %b want %b", c, busy, e_busy); end
      if (dvalid !== e_dvalid) begin n_fail++; $display("FAIL rst_mid dvalid c%0d: got %b want %b", c, dvalid, e_dvalid); end
      if (dout !== e_dout) begin n_fail++; $display("FAIL rst_mid dout c%0d: got %h want %h", c, dout, e_dout); end
      commit(st, rs, w, ^w);
    end
  endtask

  task automatic test_random();
    logic st;
    logic [DW-1:0] w;
    logic p;
    for (int c = 0; c < 8 * L; c++) begin
      st = ($urandom_range(0, 3) == 0);
      w = 8'($urandom);
      p = 1'($urandom);
      predict(st, 1'b0);
      n_checks += 3;
      if (busy !== e_busy) begin n_fail++; $display("FAIL random busy c%0d: got %b want %b", c, busy, e_busy); end
      if (dvalid !== e_dvalid) begin n_fail++; $display("FAIL random dvalid c%0d: got %b want %b", c, dvalid, e_dvalid); end
      if (dout !== e_dout) begin n_fail++; $display("FAIL random dout c%0d: got %h want %h", c, dout, e_dout); end
      if (e_dvalid) begin
        n_checks++;
        if (parity_err !== e_perr) begin n_fail++; $display("FAIL random parity_err c%0d: got %b want %b", c, parity_err, e_perr); end
      end
      commit(st, 1'b0, w, p);
    end
    predict(1'b0, 1'b0);
    for (int c = 0; c < L + 2; c++) begin
      predict(1'b0, 1'b0);
      commit(1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_small_div();
    logic [DW2-1:0] w4;
    logic eb, ev;
    logic [DW2-1:0] ed;
    int k;
    w4 = 4'h9;
    for (int c = 0; c < L2 + 4; c++) begin
      eb = (c >= 1) && (c <= L2);
      ev = (c == L2 + 1);
      ed = (c >= L2 + 1) ? w4 : 4'h0;
      s_start = (c == 0);
      if (eb) begin
        k = (c - 1) / DIV2;
        s_sin = (k < DW2) ? w4[DW2-1-k] : (^w4);
      end else begin
        s_sin = 1'($urandom);
      end
      start = 1'b0;
      rst = 1'b0;
      n_checks += 3;
      if (s_busy !== eb) begin n_fail++; $display("FAIL small busy c%0d: got %b want %b", c, s_busy, eb); end
      if (s_dvalid !== ev) begin n_fail++; $display("FAIL small dvalid c%0d: got %b want %b", c, s_dvalid, ev); end
      if (s_dout !== ed) begin n_fail++; $display("FAIL small dout c%0d: got %h want %h", c, s_dout, ed); end
      if (ev) begin
        n_checks++;
        if (s_perr !== 1'b0) begin n_fail++; $display("FAIL small parity_err c%0d: got %b want 0", c, s_perr); end
      end
      @(posedge clk);
      #1;
      g_t++;
    end
    s_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, 1'b0);
`ifdef SIPO_BR_PARITY_EN
    test_single(8'hA5, 1'b1);
`endif
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_small_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
